ariane_irq_sync: RTL and testbench
==================================

ARIANE_IRQ_SYNC -- requirements
Module: ariane_irq_sync

Interface
REQ-001 The block SHALL have parameter SyncStages, default 2: flip-flop stages in each synchronizer chain; legal range 2..4.
REQ-002 The block SHALL have parameter FilterCycles, default 3: consecutive stable cycles needed before a filtered output changes; legal range 1..15.
REQ-003 The block SHALL have port clk_i  input  1  core clock; the only clock.
REQ-004 The block SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port irq_i  input  2  async level interrupts (mip/sip sources).
REQ-006 The block SHALL have port ipi_i  input  1  async inter-processor interrupt.
REQ-007 The block SHALL have port time_irq_i  input  1  async timer interrupt.
REQ-008 The block SHALL have port debug_req_i  input  1  async debug request.
REQ-009 The block SHALL have port irq_o  output  2  synchronized, filtered irq_i, driving the core irq_i.
REQ-010 The block SHALL have port ipi_o  output  1  synchronized, filtered ipi_i.
REQ-011 The block SHALL have port time_irq_o  output  1  synchronized, filtered time_irq_i.
REQ-012 The block SHALL have port debug_req_o  output  1  synchronized, filtered debug_req_i.
REQ-013 The block SHALL have port glitch_cnt_o  output  8  saturating count of rejected glitches, all lines combined.

Function
REQ-014 Each of the 5 lines SHALL run its own SyncStages-deep chain; only the last stage feeds later logic.
REQ-015 Each filter SHALL hold output o, counter c (4 bits) and sync value s.
  - s == o: c cleared to 0.
  - s != o, c < FilterCycles-1: c increments.
  - s != o, c == FilterCycles-1: o toggles, c cleared to 0.
REQ-016 With a stable input change, an output SHALL update exactly SyncStages+FilterCycles rising edges after the first edge that samples the new level (defaults: 5).
REQ-017 A glitch SHALL increment glitch_cnt_o by 1 (saturating at 255). A glitch is: s returns to o while c != 0.
REQ-018 If several lines glitch in the same cycle, glitch_cnt_o SHALL add the number of glitching lines, saturating at 255.
REQ-019 A rising edge and a falling edge SHALL be filtered identically; the filter has no polarity bias.
REQ-020 Outputs SHALL be driven only from flops, with no combinational path from any input.
REQ-021 Parameters outside their legal range SHALL cause an elaboration-time error.

Reset
REQ-022 Asserting rst_ni low SHALL immediately clear, with no clock required:
  - all sync stages, counters and outputs to 0;
  - glitch_cnt_o to 0.
REQ-023 Reset asserted mid-filter SHALL discard any partial count; after release, a level already high SHALL take the full REQ-016 latency to appear.
REQ-024 Reset deassertion SHALL be used as-is; the integrating top ensures it is synchronized to clk_i.

Configuration
REQ-025 The macro IRQ_SYNC_FILTER_EN SHALL control the filter.
  - Defined: filters and glitch counter are compiled in per REQ-015..REQ-018.
  - Undefined: each output equals its last sync stage (latency SyncStages edges) and glitch_cnt_o is tied to 0.

Verification
REQ-026 Defaults, filter on: irq_i[0] 0->1 held -> irq_o[0] rises on the 5th edge; no other output changes.
REQ-027 Defaults: ipi_i high for 2 cycles, then low -> ipi_o stays 0 and glitch_cnt_o = 1.
REQ-028 Same-cycle 1-cycle pulses on all 5 inputs, repeated 60 times -> glitch_cnt_o saturates at 255 and all outputs stay 0.
REQ-029 time_irq_i held high, rst_ni pulsed low after 3 cycles -> time_irq_o = 0 during reset, then rises 5 edges after the first post-reset sampling edge.
REQ-030 Filter off (macro undefined), SyncStages=3: debug_req_i 1-cycle pulse -> debug_req_o 1-cycle pulse 3 edges later; glitch_cnt_o = 0.

Source files
------------

// File: rtl/ariane_irq_sync.sv
// ariane_irq_sync: per-line synchronizers plus optional debounce filters for
// the asynchronous interrupt/debug inputs of the core.
// Build macro IRQ_SYNC_FILTER_EN: when defined, each line passes through a
// stability filter and rejected glitches are counted; when undefined, each
// output is just the last synchronizer stage and glitch_cnt_o is 0.

module ariane_irq_sync_lane #(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic glitch_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  s;

  // synchronizer chain; only the last stage is used downstream
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SyncStages-2:0], d_i};
  end

  assign s = sync_q[SyncStages-1];

`ifdef IRQ_SYNC_FILTER_EN
  localparam logic [3:0] CntMax = 4'(FilterCycles - 1);

  logic       out_q, out_d;
  logic [3:0] cnt_q, cnt_d;
  logic       glitch;

  // filter decision: toggle after FilterCycles consecutive differing samples,
  // flag a glitch when the level returns before that happens
  always_comb begin
    out_d  = out_q;
    cnt_d  = '0;
    glitch = 1'b0;
    if (s != out_q) begin
      if (cnt_q == CntMax) out_d = ~out_q;
      else                 cnt_d = cnt_q + 4'd1;
    end else begin
      glitch = (cnt_q != '0);
    end
  end

  // filter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o      = out_q;
  assign glitch_o = glitch;
`else
  assign q_o      = s;
  assign glitch_o = 1'b0;
`endif

endmodule

module ariane_irq_sync #(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] irq_i,
  input  logic       ipi_i,
  input  logic       time_irq_i,
  input  logic       debug_req_i,
  output logic [1:0] irq_o,
  output logic       ipi_o,
  output logic       time_irq_o,
  output logic       debug_req_o,
  output logic [7:0] glitch_cnt_o
);

  localparam int NumLines = 5;

  if (SyncStages < 2 || SyncStages > 4) begin : g_bad_sync_stages
    $error("ariane_irq_sync: SyncStages must be in 2..4");
  end
  if (FilterCycles < 1 || FilterCycles > 15) begin : g_bad_filter_cycles
    $error("ariane_irq_sync: FilterCycles must be in 1..15");
  end

  // line order: {debug, time, ipi, irq[1], irq[0]}
  logic [NumLines-1:0] line_in, line_out, glitch;

  assign line_in = {debug_req_i, time_irq_i, ipi_i, irq_i};

  for (genvar i = 0; i < NumLines; i++) begin : g_lane
    ariane_irq_sync_lane #(
      .SyncStages  (SyncStages),
      .FilterCycles(FilterCycles)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .d_i     (line_in[i]),
      .q_o     (line_out[i]),
      .glitch_o(glitch[i])
    );
  end

  assign irq_o       = line_out[1:0];
  assign ipi_o       = line_out[2];
  assign time_irq_o  = line_out[3];
  assign debug_req_o = line_out[4];

`ifdef IRQ_SYNC_FILTER_EN
  logic [7:0] gcnt_q, gcnt_d;
  logic [2:0] n_glitch;
  logic [8:0] gsum;

  // several lanes may glitch together: add them all, clamp at 255
  always_comb begin
    n_glitch = '0;
    for (int i = 0; i < NumLines; i++) n_glitch = n_glitch + 3'(glitch[i]);
    gsum   = {1'b0, gcnt_q} + 9'(n_glitch);
    gcnt_d = gsum[8] ? 8'hff : gsum[7:0];
  end

  // glitch counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gcnt_q <= '0;
    else         gcnt_q <= gcnt_d;
  end

  assign glitch_cnt_o = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
  assign glitch_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ariane_irq_sync.sv
// Randomized + directed bench for ariane_irq_sync, checked against a
// sample-history reference model of the synchronize/filter rules.
module tb_ariane_irq_sync;

`ifdef IRQ_SYNC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int SS  = FILT ? 2 : 3;
  localparam int FC  = 3;
  localparam int LAT = FILT ? SS + FC : SS;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [1:0] irq_i;
  logic       ipi_i, time_irq_i, debug_req_i;
  logic [1:0] irq_o;
  logic       ipi_o, time_irq_o, debug_req_o;
  logic [7:0] glitch_cnt_o;

  ariane_irq_sync #(.SyncStages(SS), .FilterCycles(FC)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .irq_i       (irq_i),
    .ipi_i       (ipi_i),
    .time_irq_i  (time_irq_i),
    .debug_req_i (debug_req_i),
    .irq_o       (irq_o),
    .ipi_o       (ipi_o),
    .time_irq_o  (time_irq_o),
    .debug_req_o (debug_req_o),
    .glitch_cnt_o(glitch_cnt_o)
  );

  always #5 clk = ~clk;

  // reference model: every sampled input vector since reset, plus filter state
  logic [4:0] seen[$];
  logic [4:0] exp_o;
  int         run[5];
  int         exp_g;
  int         checks = 0;
  int         fails  = 0;
  logic [4:0] cur;

  task automatic model_clear();
    seen.delete();
    exp_o = '0;
    exp_g = 0;
    for (int l = 0; l < 5; l++) run[l] = 0;
  endtask

  task automatic model_edge(input logic [4:0] in);
    int   n;
    int   g;
    logic s;
    seen.push_back(in);
    n = seen.size();
    g = 0;
    for (int l = 0; l < 5; l++) begin
      if (FILT) begin
        // value sampled SS edges before this one reaches the filter now
        s = (n > SS) ? seen[n-1-SS][l] : 1'b0;
        if (s != exp_o[l]) begin
          run[l]++;
          if (run[l] == FC) begin
            exp_o[l] = s;
            run[l]   = 0;
          end
        end else begin
          if (run[l] != 0) g++;
          run[l] = 0;
        end
      end else begin
        exp_o[l] = (n >= SS) ? seen[n-SS][l] : 1'b0;
      end
    end
    exp_g = (exp_g + g > 255) ? 255 : exp_g + g;
  endtask

  task automatic check(input string tag);
    logic [4:0] obs;
    logic [7:0] eg;
    obs = {debug_req_o, time_irq_o, ipi_o, irq_o};
    eg  = 8'(exp_g);
    checks++;
    assert (obs === exp_o) else begin
      fails++;
      $error("FAIL %s outputs got %b want %b", tag, obs, exp_o);
    end
    checks++;
    assert (glitch_cnt_o === eg) else begin
      fails++;
      $error("FAIL %s glitch_cnt got %0d want %0d", tag, glitch_cnt_o, eg);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    cur         = v;
    irq_i       = v[1:0];
    ipi_i       = v[2];
    time_irq_i  = v[3];
    debug_req_i = v[4];
  endtask

  // called just after a posedge (or at the reset-release negedge)
  task automatic step(input logic [4:0] v, input string tag);
    drive(v);
    @(posedge clk);
    model_edge(v);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    model_clear();
    #1 check(tag);
    @(posedge clk);
    #1 check(tag);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(5'b0);
    model_clear();
    #3 check("reset_state");
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 3; i++) step(5'b0, "idle");

    // stable rise on irq[0]
    for (int i = 1; i <= 8; i++) begin
      step(5'b00001, "irq0_rise");
      if (i == LAT - 1) chk1("irq0_before_lat", 8'(irq_o[0]), 8'd0);
      if (i == LAT)     chk1("irq0_at_lat", 8'(irq_o[0]), 8'd1);
    end
    // stable fall: same latency
    for (int i = 1; i <= 8; i++) begin
      step(5'b00000, "irq0_fall");
      if (i == LAT - 1) chk1("irq0_fall_before_lat", 8'(irq_o[0]), 8'd1);
      if (i == LAT)     chk1("irq0_fall_at_lat", 8'(irq_o[0]), 8'd0);
    end

    // 2-cycle ipi blip
    step(5'b00100, "ipi_blip");
    step(5'b00100, "ipi_blip");
    for (int i = 0; i < 8; i++) step(5'b0, "ipi_blip_tail");
    chk1("ipi_blip_glitch", glitch_cnt_o, FILT ? 8'd1 : 8'd0);

    // all-line 1-cycle pulses: counter must clamp
    for (int i = 0; i < 60; i++) begin
      step(5'b11111, "pulse_all");
      step(5'b00000, "pulse_all");
    end
    for (int i = 0; i < 6; i++) step(5'b0, "pulse_tail");
    chk1("glitch_saturated", glitch_cnt_o, FILT ? 8'd255 : 8'd0);

    // reset in the middle of a time_irq rise
    do_reset("reset_clear");
    for (int i = 0; i < 3; i++) step(5'b01000, "time_pre");
    do_reset("reset_mid");
    chk1("time_in_reset", 8'(time_irq_o), 8'd0);
    for (int i = 1; i <= 8; i++) begin
      step(5'b01000, "time_post");
      if (i == LAT - 1) chk1("time_before_lat", 8'(time_irq_o), 8'd0);
      if (i == LAT)     chk1("time_at_lat", 8'(time_irq_o), 8'd1);
    end

    // single-cycle debug pulse
    do_reset("reset_dbg");
    for (int i = 1; i <= 8; i++) begin
      step((i == 1) ? 5'b10000 : 5'b00000, "dbg_pulse");
      if (i == LAT)     chk1("dbg_at_lat", 8'(debug_req_o), FILT ? 8'd0 : 8'd1);
      if (i == LAT + 1) chk1("dbg_after_lat", 8'(debug_req_o), 8'd0);
    end
    chk1("dbg_glitch", glitch_cnt_o, FILT ? 8'd1 : 8'd0);

    // random phase: alternate noisy and calm windows, one reset midway
    for (int i = 0; i < 400; i++) begin
      logic [4:0] v;
      int         thr;
      thr = ((i / 40) % 2 == 0) ? 4 : 1;
      v   = cur;
      for (int l = 0; l < 5; l++)
        if ($urandom_range(0, 7) < thr) v[l] = ~v[l];
      step(v, "random");
      if (i == 200) do_reset("reset_random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
